// File: rtl/aire_ctrl_param_if.sv
// Front-panel / status bundle between the panel-side driver and the A/C controller.
// The master side drives power, fault and raw buttons. The slave side (the controller) drives
// state, fan speed, set-point and sleep-timer status. Widths follow the controller parameters.
interface aire_ctrl_param_if #(
  parameter int N_VEL     = 4,
  parameter int N_TEMP    = 8,
  parameter int SLEEP_CYC = 1000
);
  localparam int VW = (N_VEL  > 1) ? $clog2(N_VEL)  : 1;
  localparam int TW = (N_TEMP > 1) ? $clog2(N_TEMP) : 1;
  localparam int SW = $clog2(SLEEP_CYC + 1);

  logic          on;          // master power switch (level)
  logic          fault;       // sensor fault status (1 = fault)
  logic          pb_vel_up;   // raw button: speed +1
  logic          pb_vel_dn;   // raw button: speed -1
  logic          pb_temp_up;  // raw button: set-point +1
  logic          pb_temp_dn;  // raw button: set-point -1
  logic          pb_sleep;    // raw button: arm / re-arm sleep timer
  logic [2:0]    state;       // 0 OFF, 1 START, 2 RUN, 3 FAULT, 4 SLEPT
  logic [VW-1:0] vel;         // fan speed index, 0 unless RUN
  logic [TW-1:0] temp;        // set-point index, 0 unless powered
  logic          sleep_act;   // sleep timer armed and counting
  logic [SW-1:0] sleep_left;  // remaining sleep cycles

  modport master (
    output on, fault, pb_vel_up, pb_vel_dn, pb_temp_up, pb_temp_dn, pb_sleep,
    input  state, vel, temp, sleep_act, sleep_left
  );

  modport slave (
    input  on, fault, pb_vel_up, pb_vel_dn, pb_temp_up, pb_temp_dn, pb_sleep,
    output state, vel, temp, sleep_act, sleep_left
  );
endinterface

// File: rtl/aire_ctrl_param.sv
// Air-conditioner controller: 5-button debounce, saturating speed/set-point, start-up delay,
// fault lockout and sleep timer. Latency: raw press -> vel/temp change = DEB_CYC+2 cycles.
// No backpressure: inputs are levels sampled every cycle, outputs are registered levels.
// Ports: clock_i / reset_i (synchronous, active-high) plus the slave side of aire_ctrl_param_if
// (on, fault, pb_* in; state, vel, temp, sleep_act, sleep_left out).
module aire_ctrl_param #(
  parameter int N_VEL     = 4,
  parameter int N_TEMP    = 8,
  parameter int TEMP_INIT = 3,
  parameter int DEB_CYC   = 4,
  parameter int START_CYC = 8,
  parameter int SLEEP_CYC = 1000
) (
  input  logic               clock_i,
  input  logic               reset_i,
  aire_ctrl_param_if.slave   bus
);

  localparam int VW = (N_VEL  > 1) ? $clog2(N_VEL)  : 1;
  localparam int TW = (N_TEMP > 1) ? $clog2(N_TEMP) : 1;
  localparam int SW = $clog2(SLEEP_CYC + 1);
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int CW = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam int NB = 5;

  localparam logic [VW-1:0] VMAX = VW'(N_VEL - 1);
  localparam logic [TW-1:0] TMAX = TW'(N_TEMP - 1);

  // Button bit positions in the debounce vectors.
  localparam int B_VUP = 0;
  localparam int B_VDN = 1;
  localparam int B_TUP = 2;
  localparam int B_TDN = 3;
  localparam int B_SLP = 4;

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_FAULT = 3'd3,
    S_SLEPT = 3'd4
  } state_e;

  state_e         state_q;
  logic [CW-1:0]  scnt_q;
  logic           sact_q;
  logic [SW-1:0]  sleft_q;
  logic [VW-1:0]  vel_q;
  logic [TW-1:0]  temp_q;

  logic [NB-1:0]  raw;
  logic [NB-1:0]  lvl_q, lvl_d;
  logic [NB-1:0]  prv_q;
  logic [NB-1:0]  press;
  logic [DW-1:0]  dcnt_q [NB];
  logic [DW-1:0]  dcnt_d [NB];

  logic [VW-1:0]  spd_q, spd_d;
  logic [TW-1:0]  sp_q, sp_d;
  logic           upd_en;

  assign raw = {bus.pb_sleep, bus.pb_temp_dn, bus.pb_temp_up, bus.pb_vel_dn, bus.pb_vel_up};

  // Debounce: the counter tracks how many consecutive samples disagree with the accepted level;
  // the DEB_CYC-th disagreeing sample flips the level, any agreeing sample restarts the count.
  always_comb begin
    lvl_d = lvl_q;
    for (int b = 0; b < NB; b++) begin
      dcnt_d[b] = '0;
      if (raw[b] != lvl_q[b]) begin
        if (dcnt_q[b] == DW'(DEB_CYC - 1)) begin
          lvl_d[b] = raw[b];
        end else begin
          dcnt_d[b] = dcnt_q[b] + 1'b1;
        end
      end
    end
  end

  // One pulse per accepted rising level, in the cycle after the level flips.
  assign press = lvl_q & ~prv_q;

  // Speed / set-point: opposing pulses in one cycle cancel; both saturate at their range ends.
  always_comb begin
    upd_en = bus.on && (state_q != S_FAULT);
    spd_d  = spd_q;
    sp_d   = sp_q;
    if (upd_en) begin
      if (press[B_VUP] && !press[B_VDN] && (spd_q != VMAX)) begin
        spd_d = spd_q + 1'b1;
      end else if (press[B_VDN] && !press[B_VUP] && (spd_q != '0)) begin
        spd_d = spd_q - 1'b1;
      end
      if (press[B_TUP] && !press[B_TDN] && (sp_q != TMAX)) begin
        sp_d = sp_q + 1'b1;
      end else if (press[B_TDN] && !press[B_TUP] && (sp_q != '0)) begin
        sp_d = sp_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      lvl_q  <= '0;
      prv_q  <= '0;
      dcnt_q <= '{default: '0};
      spd_q  <= '0;
      sp_q   <= TW'(TEMP_INIT);
      temp_q <= '0;
    end else begin
      lvl_q  <= lvl_d;
      prv_q  <= lvl_q;
      dcnt_q <= dcnt_d;
      spd_q  <= spd_d;
      sp_q   <= sp_d;
      temp_q <= bus.on ? sp_q : '0;
    end
  end

  // Main FSM with the sleep timer folded in. vel_q is written alongside every state change so
  // the fan index is only ever non-zero in the same cycle that state reads RUN.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_OFF;
      scnt_q  <= '0;
      sact_q  <= 1'b0;
      sleft_q <= '0;
      vel_q   <= '0;
    end else if (!bus.on) begin
      state_q <= S_OFF;
      sact_q  <= 1'b0;
      sleft_q <= '0;
      vel_q   <= '0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_q <= S_START;
          scnt_q  <= CW'(START_CYC - 1);
          vel_q   <= '0;
        end
        S_START: begin
          vel_q <= '0;
          if (bus.fault) begin
            state_q <= S_FAULT;
          end else if (scnt_q == '0) begin
            state_q <= S_RUN;
            vel_q   <= spd_q;
          end else begin
            scnt_q <= scnt_q - 1'b1;
          end
        end
        S_RUN: begin
          if (bus.fault) begin
            state_q <= S_FAULT;
            sact_q  <= 1'b0;
            sleft_q <= '0;
            vel_q   <= '0;
          end else if (sact_q && (sleft_q == SW'(1))) begin
            // Last counted cycle: fan goes off and the timer disarms together.
            state_q <= S_SLEPT;
            sact_q  <= 1'b0;
            sleft_q <= '0;
            vel_q   <= '0;
          end else begin
            vel_q <= spd_q;
            if (press[B_SLP]) begin
              sact_q  <= 1'b1;
              sleft_q <= SW'(SLEEP_CYC);
            end else if (sact_q) begin
              sleft_q <= sleft_q - 1'b1;
            end
          end
        end
        S_FAULT, S_SLEPT: begin
          vel_q <= '0;
        end
        default: begin
          state_q <= S_OFF;
          sact_q  <= 1'b0;
          sleft_q <= '0;
          vel_q   <= '0;
        end
      endcase
    end
  end

  assign bus.state      = state_q;
  assign bus.vel        = vel_q;
  assign bus.temp       = temp_q;
  assign bus.sleep_act  = sact_q;
  assign bus.sleep_left = sleft_q;

endmodule
